// File: rtl/serial_sub_pkg.sv
// ---------------------------------------------------------------------------
// serial_sub_pkg
// Shared definitions for the bit-serial subtractor:
//   - DEFAULT_WIDTH : default operand/result width
//   - state_t       : FSM state encoding (S_IDLE, S_SHIFT, S_DONE)
// No ports (package).
// ---------------------------------------------------------------------------
package serial_sub_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

endpackage : serial_sub_pkg

// File: rtl/serial_subtractor_if.sv
// ---------------------------------------------------------------------------
// serial_subtractor_if
// Operand/result handshake bundle for serial_subtractor.
//   in_valid/in_ready/a/b       : operand pair, valid/ready
//   out_valid/out_ready/diff/bout : result, valid/ready
// Modports:
//   master : producer/consumer side (drives operands, out_ready)
//   slave  : the subtractor (drives in_ready, out_valid, diff, bout)
// ---------------------------------------------------------------------------
interface serial_subtractor_if
    import serial_sub_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] diff;
    logic             bout;

    modport master (
        output in_valid, a, b, out_ready,
        input  in_ready, out_valid, diff, bout
    );

    modport slave (
        input  in_valid, a, b, out_ready,
        output in_ready, out_valid, diff, bout
    );
endinterface : serial_subtractor_if

// File: rtl/full_subtractor_bit.sv
// ---------------------------------------------------------------------------
// full_subtractor_bit
// One-bit a - b - bin built from two half subtractors.
//   a, b : operand bits (in)
//   bin  : borrow in (in)
//   d    : difference bit (out)
//   bo   : borrow out (out)
// ---------------------------------------------------------------------------
module full_subtractor_bit (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bo
);
    logic d1;
    logic bo1;
    logic bo2;

    half_subtractor u_hs_ab (
        .x  (a),
        .y  (b),
        .d  (d1),
        .bo (bo1)
    );

    // Second stage subtracts the incoming borrow from the partial difference.
    half_subtractor u_hs_bin (
        .x  (d1),
        .y  (bin),
        .d  (d),
        .bo (bo2)
    );

    // The two stages can never both borrow, so OR is the full borrow.
    assign bo = bo1 | bo2;
endmodule : full_subtractor_bit

// File: rtl/half_subtractor.sv
// ---------------------------------------------------------------------------
// half_subtractor
// One-bit x - y without borrow-in.
//   x, y : operand bits (in)
//   d    : difference bit x ^ y (out)
//   bo   : borrow out, set when x=0 and y=1 (out)
// ---------------------------------------------------------------------------
module half_subtractor (
    input  logic x,
    input  logic y,
    output logic d,
    output logic bo
);
    assign d  = x ^ y;
    assign bo = ~x & y;
endmodule : half_subtractor

// File: rtl/serial_subtractor.sv
// ---------------------------------------------------------------------------
// serial_subtractor
// Bit-serial WIDTH-bit subtractor: diff = a - b, LSB first, one bit per clock.
// Operands accepted on a valid/ready handshake, result returned on another.
// Result appears WIDTH edges after the accept edge; one op per WIDTH+2 cycles.
//
// Ports:
//   clk : clock, rising edge
//   rst : asynchronous, active-high reset
//   bus : serial_subtractor_if.slave
//         in_valid/in_ready/a/b, out_valid/out_ready/diff/bout
//
// Build option:
//   SERIAL_SUB_SAT_EN : when defined, an underflowing result (final borrow 1)
//                       is floored to zero; bout still reports the borrow.
// ---------------------------------------------------------------------------
module serial_subtractor
    import serial_sub_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input logic                clk,
    input logic                rst,
    serial_subtractor_if.slave bus
);
    state_t           state_q;
    state_t           state_d;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] res_sh;
    logic [WIDTH-1:0] res_next;
    logic [WIDTH-1:0] diff_q;
    logic [CNT_W-1:0] cnt_q;
    logic             br_q;
    logic             bout_q;
    logic             d_bit;
    logic             br_next;
    logic             last_bit;

    full_subtractor_bit u_fsb (
        .a   (a_sh[0]),
        .b   (b_sh[0]),
        .bin (br_q),
        .d   (d_bit),
        .bo  (br_next)
    );

    assign last_bit = (cnt_q == CNT_W'(WIDTH - 1));

    // New difference bit enters at the MSB; after WIDTH shifts the LSB sits at bit 0.
    assign res_next = (res_sh >> 1) | (WIDTH'(d_bit) << (WIDTH - 1));

    // NOTE: every output of a combinational block is assigned a default first,
    // so no path through the case statement can leave it unassigned (latch).
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (bus.in_valid)  state_d = S_SHIFT;
            S_SHIFT: if (last_bit)      state_d = S_DONE;
            S_DONE:  if (bus.out_ready) state_d = S_IDLE;
            default:                    state_d = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // the pre-edge value of its inputs regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_sh   <= '0;
            b_sh   <= '0;
            res_sh <= '0;
            diff_q <= '0;
            cnt_q  <= '0;
            br_q   <= 1'b0;
            bout_q <= 1'b0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (bus.in_valid) begin
                        a_sh  <= bus.a;
                        b_sh  <= bus.b;
                        br_q  <= 1'b0;
                        cnt_q <= '0;
                    end
                end
                S_SHIFT: begin
                    a_sh   <= a_sh >> 1;
                    b_sh   <= b_sh >> 1;
                    res_sh <= res_next;
                    br_q   <= br_next;
                    cnt_q  <= cnt_q + CNT_W'(1);
                    // Visible result is only updated on entry to DONE.
                    if (last_bit) begin
                        bout_q <= br_next;
`ifdef SERIAL_SUB_SAT_EN
                        diff_q <= br_next ? '0 : res_next;
`else
                        diff_q <= res_next;
`endif
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready  = (state_q == S_IDLE);
    assign bus.out_valid = (state_q == S_DONE);
    assign bus.diff      = diff_q;
    assign bus.bout      = bout_q;
endmodule : serial_subtractor

// File: tb/tb_serial_subtractor.sv
// ---------------------------------------------------------------------------
// tb_serial_subtractor
// Self-checking bench for serial_subtractor (WIDTH=8). Expected results come
// from an arithmetic reference model; honours SERIAL_SUB_SAT_EN.
// ---------------------------------------------------------------------------
module tb_serial_subtractor;
    localparam int W = 8;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_pass;

    serial_subtractor_if #(.WIDTH(W)) bus ();

    serial_subtractor #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    endtask

    // Reference: unsigned subtraction with plain integer arithmetic.
    function automatic logic [W-1:0] model_diff(input logic [W-1:0] x, input logic [W-1:0] y);
        int r;
        r = int'(x) - int'(y);
        if (r < 0) begin
`ifdef SERIAL_SUB_SAT_EN
            return '0;
`else
            return W'(r + (1 << W));
`endif
        end
        return W'(r);
    endfunction

    function automatic logic model_bout(input logic [W-1:0] x, input logic [W-1:0] y);
        return x < y;
    endfunction

    // Called at a negedge with the block idle; returns at the first negedge after accept.
    task automatic issue(input string tag, input logic [W-1:0] av, input logic [W-1:0] bv);
        check({tag, "_in_ready"}, 64'(bus.in_ready), 64'd1);
        bus.a        = av;
        bus.b        = bv;
        bus.in_valid = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    // Called at the first negedge after accept; returns at the negedge where out_valid is seen.
    task automatic await_result(input string tag, input logic [W-1:0] av, input logic [W-1:0] bv);
        int edges;
        edges = 0;
        while (!bus.out_valid && edges < 40) begin
            @(negedge clk);
            edges++;
        end
        check({tag, "_latency"}, 64'(edges), 64'(W));
        check({tag, "_diff"}, 64'(bus.diff), 64'(model_diff(av, bv)));
        check({tag, "_bout"}, 64'(bus.bout), 64'(model_bout(av, bv)));
    endtask

    task automatic handoff(input string tag);
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        check({tag, "_valid_drop"}, 64'(bus.out_valid), 64'd0);
        check({tag, "_idle"}, 64'(bus.in_ready), 64'd1);
    endtask

    task automatic full_op(input string tag, input logic [W-1:0] av, input logic [W-1:0] bv);
        issue(tag, av, bv);
        await_result(tag, av, bv);
        handoff(tag);
    endtask

    initial begin
        logic [W-1:0] na;
        logic [W-1:0] nb;
        logic [W-1:0] qa[$];
        logic [W-1:0] qb[$];
        logic [W-1:0] ea;
        logic [W-1:0] eb;
        logic [W-1:0] held_diff;
        logic         held_bout;
        bit           seen_valid;
        bit           need_new;
        int           cyc;
        int           last_ov;
        int           n_acc;
        int           n_res;

        n_checks      = 0;
        n_pass        = 0;
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.a         = '0;
        bus.b         = '0;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_in_ready", 64'(bus.in_ready), 64'd1);
        check("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("rst_diff", 64'(bus.diff), 64'd0);
        check("rst_bout", 64'(bus.bout), 64'd0);
        rst = 1'b0;
        @(negedge clk);

        // Basic and underflow
        full_op("basic", 8'd200, 8'd55);
        full_op("under", 8'd3, 8'd5);

        // Edge operands
        full_op("equal", 8'hA5, 8'hA5);
        full_op("zero_minus_max", 8'h00, 8'hFF);
        full_op("max_minus_zero", 8'hFF, 8'h00);

        // Reset in the middle of a shift: result of last op (FF) is wiped.
        issue("midrst", 8'h55, 8'h11);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        check("midrst_in_ready", 64'(bus.in_ready), 64'd1);
        check("midrst_out_valid", 64'(bus.out_valid), 64'd0);
        check("midrst_diff", 64'(bus.diff), 64'd0);
        check("midrst_bout", 64'(bus.bout), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        seen_valid = 1'b0;
        repeat (12) begin
            @(negedge clk);
            if (bus.out_valid) seen_valid = 1'b1;
        end
        check("midrst_no_valid", 64'(seen_valid), 64'd0);

        // Backpressure: result held while out_ready=0, new op waits for handoff.
        issue("bp", 8'd77, 8'd99);
        await_result("bp", 8'd77, 8'd99);
        held_diff    = bus.diff;
        held_bout    = bus.bout;
        na           = W'($urandom);
        nb           = W'($urandom);
        bus.a        = na;
        bus.b        = nb;
        bus.in_valid = 1'b1;
        repeat (5) begin
            @(negedge clk);
            check("bp_valid_hold", 64'(bus.out_valid), 64'd1);
            check("bp_diff_hold", 64'(bus.diff), 64'(model_diff(8'd77, 8'd99)));
            check("bp_bout_hold", 64'(bus.bout), 64'(held_bout));
            check("bp_busy", 64'(bus.in_ready), 64'd0);
        end
        check("bp_diff_latched", 64'(held_diff), 64'(model_diff(8'd77, 8'd99)));
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        check("bp_handoff_valid", 64'(bus.out_valid), 64'd0);
        check("bp_handoff_ready", 64'(bus.in_ready), 64'd1);
        @(negedge clk);
        bus.in_valid = 1'b0;
        check("bp_new_accepted", 64'(bus.in_ready), 64'd0);
        await_result("bp_new", na, nb);
        handoff("bp_new");

        // Back-to-back random stream with in_valid and out_ready held high.
        cyc           = 0;
        last_ov       = -1;
        n_acc         = 0;
        n_res         = 0;
        need_new      = 1'b0;
        bus.a         = W'($urandom);
        bus.b         = W'($urandom);
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        while (n_res < 100 && cyc < 3000) begin
            if (bus.out_valid) begin
                if (qa.size() == 0) begin
                    check("b2b_unexpected_result", 64'd1, 64'd0);
                end else begin
                    ea = qa.pop_front();
                    eb = qb.pop_front();
                    check("b2b_diff", 64'(bus.diff), 64'(model_diff(ea, eb)));
                    check("b2b_bout", 64'(bus.bout), 64'(model_bout(ea, eb)));
                end
                if (last_ov >= 0) check("b2b_period", 64'(cyc - last_ov), 64'(W + 2));
                last_ov = cyc;
                n_res++;
            end
            if (need_new) begin
                need_new = 1'b0;
                if (n_acc == 100) bus.in_valid = 1'b0;
                else begin
                    bus.a = W'($urandom);
                    bus.b = W'($urandom);
                end
            end
            if (bus.in_ready && bus.in_valid) begin
                qa.push_back(bus.a);
                qb.push_back(bus.b);
                n_acc++;
                need_new = 1'b1;
            end
            @(negedge clk);
            cyc++;
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        check("b2b_result_count", 64'(n_res), 64'd100);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule : tb_serial_subtractor
